// File: rtl/regfile_alu_sequencer_pkg.sv
// rtl/regfile_alu_sequencer_pkg.sv - shared state encoding and ALU opcode constants
package regfile_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB_LO = 3'd3,
    ST_WB_HI = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

endpackage

// File: rtl/regfile_alu_sequencer_regfile_array.sv
// rtl/regfile_alu_sequencer_regfile_array.sv - NREGS x WIDTH array, one sync write port, three async read ports
module regfile_alu_sequencer_regfile_array #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [ADDR_W-1:0] raddr_c,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic [WIDTH-1:0]  rdata_c
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
  assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/regfile_alu_sequencer.sv
// rtl/regfile_alu_sequencer.sv - register file plus fetch/exec/writeback sequencer driving an external ALU
module regfile_alu_sequencer #(
  parameter int         WIDTH   = 8,
  parameter int         NREGS   = 8,
  parameter int         ADDR_W  = 3,
  parameter int         ALU_LAT = 1,
  parameter logic [1:0] OP_MUL  = 2'b11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ADDR_W-1:0]  cmd_rs1,
  input  logic [ADDR_W-1:0]  cmd_rs2,
  input  logic [ADDR_W-1:0]  cmd_rd,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  input  logic [2*WIDTH-1:0] alu_product,
  output logic               done,
  output logic               flag_c,
  output logic               flag_v
);

  import regfile_alu_sequencer_pkg::*;

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  state_t            state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]  lat_cnt;
  logic [WIDTH-1:0]  lo_q;
  logic [WIDTH-1:0]  hi_q;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata;
  logic [WIDTH-1:0]  rf_rdata_a;
  logic [WIDTH-1:0]  rf_rdata_b;

  regfile_alu_sequencer_regfile_array #(
    .WIDTH  (WIDTH),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs1_q),
    .raddr_b (rs2_q),
    .raddr_c (rd_addr),
    .rdata_a (rf_rdata_a),
    .rdata_b (rf_rdata_b),
    .rdata_c (rd_data)
  );

  assign cmd_ready = (state == ST_IDLE);

  // Host loads share the single write port and only get it while idle; busy-time loads are dropped.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    case (state)
      ST_IDLE: rf_we = wr_en;
      ST_WB_LO: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = lo_q;
      end
      ST_WB_HI: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q + ADDR_W'(1);
        rf_wdata = hi_q;
      end
      default: rf_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      lat_cnt <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      done    <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            rd_q  <= cmd_rd;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          alu_a   <= rf_rdata_a;
          alu_b   <= rf_rdata_b;
          alu_op  <= op_q;
          lat_cnt <= '0;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (lat_cnt == CNT_LAST) begin
            hi_q <= alu_product[2*WIDTH-1:WIDTH];
            if (op_q == OP_MUL) begin
              lo_q   <= alu_product[WIDTH-1:0];
              flag_c <= 1'b0;
              flag_v <= |alu_product[2*WIDTH-1:WIDTH];
            end else begin
              lo_q   <= alu_result;
              flag_c <= alu_carry;
              flag_v <= alu_overflow;
            end
            state <= ST_WB_LO;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        ST_WB_LO: begin
          if (op_q == OP_MUL) begin
            state <= ST_WB_HI;
          end else begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        ST_WB_HI: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// tb/tb_regfile_alu_sequencer.sv - scoreboard bench with behavioural ALU and register-file model
module tb_regfile_alu_sequencer;
  import regfile_alu_sequencer_pkg::*;

  localparam int W   = 8;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [AW-1:0]  cmd_rs1, cmd_rs2, cmd_rd;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [W-1:0]   wr_data;
  logic [AW-1:0]  rd_addr;
  logic [W-1:0]   rd_data;
  logic [W-1:0]   alu_a, alu_b;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_result;
  logic           alu_carry, alu_overflow;
  logic [2*W-1:0] alu_product;
  logic           done, flag_c, flag_v;

  regfile_alu_sequencer #(
    .WIDTH(W), .NREGS(N), .ADDR_W(AW), .ALU_LAT(LAT), .OP_MUL(OP_MUL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_product(alu_product),
    .done(done), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // External ALU behaviour; mul drives a decoy result/carry and non-mul a decoy product.
  typedef struct {
    logic [W-1:0]   res;
    logic           c;
    logic           v;
    logic [2*W-1:0] prod;
  } alu_t;

  function automatic alu_t alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_t r;
    logic [W:0] s;
    r.prod = {~a, ~b};
    r.c = 1'b0;
    r.v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r.res = s[W-1:0];
        r.c = s[W];
        r.v = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r.res = s[W-1:0];
        r.c = s[W];
        r.v = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
      end
      OP_AND: r.res = a & b;
      default: begin
        r.prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r.res = ~r.prod[W-1:0];
        r.c = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Outputs are garbage until the inputs have been steady long enough to settle.
  logic [2*W+1:0] alu_last;
  int alu_since = 0;
  always @(negedge clk) begin
    alu_t r;
    if ({alu_op, alu_a, alu_b} !== alu_last) alu_since = 0;
    else alu_since++;
    alu_last = {alu_op, alu_a, alu_b};
    if (alu_since >= LAT - 1) begin
      r = alu_fn(alu_op, alu_a, alu_b);
      alu_result = r.res; alu_carry = r.c; alu_overflow = r.v; alu_product = r.prod;
    end else begin
      alu_result = W'($urandom); alu_carry = 1'($urandom);
      alu_overflow = 1'($urandom); alu_product = (2*W)'($urandom);
    end
  end

  typedef struct {
    logic [AW-1:0] rd;
    logic          mul;
    logic [W-1:0]  lo, hi;
    logic          fc, fv;
    int            done_cyc;
  } exp_t;

  exp_t sbq[$];
  logic [W-1:0] model [N];

  exp_t          mon_e;
  logic [AW-1:0] mon_a1;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_cycle", cyc, mon_e.done_cyc);
        chk("flag_c", flag_c, mon_e.fc);
        chk("flag_v", flag_v, mon_e.fv);
        rd_addr = mon_e.rd;
        #1 chk("wb_lo", rd_data, mon_e.lo);
        if (mon_e.mul) begin
          mon_a1 = mon_e.rd + 1'b1;
          rd_addr = mon_a1;
          #1 chk("wb_hi", rd_data, mon_e.hi);
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input bit wr, input logic [AW-1:0] wa,
                       input logic [W-1:0] wd);
    int n = 0;
    exp_t e;
    alu_t r;
    logic [AW-1:0] rd1;
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 1'b0; return; end
    if (wr) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      model[wa] = wd;
    end
    r = alu_fn(op, model[rs1], model[rs2]);
    e.rd = rd;
    e.mul = (op == OP_MUL);
    e.lo = e.mul ? r.prod[W-1:0] : r.res;
    e.hi = r.prod[2*W-1:W];
    e.fc = e.mul ? 1'b0 : r.c;
    e.fv = e.mul ? (|e.hi) : r.v;
    e.done_cyc = cyc + 1 + 2 + LAT + (e.mul ? 1 : 0);
    model[rd] = e.lo;
    if (e.mul) begin rd1 = rd + 1'b1; model[rd1] = e.hi; end
    sbq.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0; wr_en = 1'b0;
    cmd_op = 2'($urandom); cmd_rs1 = AW'($urandom); cmd_rs2 = AW'($urandom); cmd_rd = AW'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || !cmd_ready) && n < 300) begin @(negedge clk); n++; end
    chk("idle_wait", (sbq.size() == 0) && cmd_ready, 1);
    @(negedge clk);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic busy_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_reg(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
    rd_addr = a;
    #1 chk(name, rd_data, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] rop;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < N; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_flags", {flag_c, flag_v}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-EXEC aborts the command without writeback.
    host_write(1, 8'h05);
    host_write(2, 8'h03);
    issue(OP_ADD, 1, 2, 3, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    for (int i = 0; i < N; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) read_reg("abort_reg_zero", AW'(i), 8'h00);
    chk("abort_cmd_ready", cmd_ready, 1);
    repeat (10) @(negedge clk);

    // ADD with carry.
    host_write(1, 8'hF0);
    host_write(2, 8'h20);
    issue(OP_ADD, 1, 2, 3, 0, 0, 0);
    wait_idle();
    read_reg("add_reg3", 3, 8'h10);
    chk("add_flag_c", flag_c, 1);

    // MUL with rd at the top register: hi half wraps to reg0.
    host_write(1, 8'h10);
    host_write(2, 8'h20);
    issue(OP_MUL, 1, 2, 7, 0, 0, 0);
    wait_idle();
    read_reg("mul_reg7", 7, 8'h00);
    read_reg("mul_reg0", 0, 8'h02);
    chk("mul_flag_v", flag_v, 1);

    // Back-to-back with the second op reading the first op's destination.
    issue(OP_ADD, 1, 2, 5, 0, 0, 0);
    issue(OP_SUB, 5, 1, 6, 0, 0, 0);
    wait_idle();
    read_reg("b2b_reg5", 5, 8'h30);
    read_reg("b2b_reg6", 6, 8'h20);

    // Same-cycle host load is seen by FETCH; a load during EXEC is dropped.
    issue(OP_SUB, 1, 1, 4, 1, 1, 8'h7F);
    wait_idle();
    read_reg("race_reg4", 4, 8'h00);
    read_reg("race_reg1", 1, 8'h7F);
    issue(OP_ADD, 2, 2, 0, 0, 0, 0);
    @(negedge clk);
    busy_write(2, 8'hAA);
    wait_idle();
    read_reg("drop_reg2", 2, 8'h20);
    read_reg("drop_reg0", 0, 8'h40);

    for (int it = 0; it < 80; it++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 3))
        0: begin wait_idle(); host_write(AW'($urandom), W'($urandom)); end
        1: issue(rop, AW'($urandom), AW'($urandom), AW'($urandom), 0, 0, 0);
        2: begin
          wait_idle();
          issue(rop, AW'($urandom), AW'($urandom), AW'($urandom), 1, AW'($urandom), W'($urandom));
        end
        default: begin
          issue(rop, AW'($urandom), AW'($urandom), AW'($urandom), 0, 0, 0);
          busy_write(AW'($urandom), W'($urandom));
        end
      endcase
    end
    wait_idle();
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) read_reg("final_reg", AW'(i), model[i]);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
